// File: rtl/data_mem_responder.sv
// Data-memory responder for the core's M stage: word RAM plus an MMIO page
// (cycle counter, GPIO, tohost, timer). Define DMEM_TIMER_EN to build the countdown timer.
module data_mem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF_0000,
    parameter logic [31:0] BAD_READ  = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [31:0] data_addr_m,
    input  logic [31:0] write_data_m,
    output logic [31:0] read_data_m,
    output logic [31:0] gpio_out,
    output logic        done,
    output logic [31:0] exit_code,
    output logic        timer_irq,
    output logic        bus_err,
    output logic        misalign_err
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [5:0] OFF_CYCLE_LO  = 6'h00;
    localparam logic [5:0] OFF_CYCLE_HI  = 6'h01;
    localparam logic [5:0] OFF_GPIO      = 6'h02;
    localparam logic [5:0] OFF_TOHOST    = 6'h03;
    localparam logic [5:0] OFF_TIMER     = 6'h04;
    localparam logic [5:0] OFF_TIMER_ACK = 6'h05;

    logic [31:0]   r_mem [DEPTH];
    logic [63:0]   r_cycle;
    logic [31:0]   r_gpio;
    logic          r_done;
    logic [31:0]   r_exit_code;
    logic          r_bus_err;
    logic          r_misalign_err;

    logic          w_ram_hit;
    logic          w_mmio_hit;
    logic [AW-1:0] w_word_idx;
    logic [5:0]    w_off;
    logic          w_off_known;
    logic          w_wr_ram;
    logic          w_wr_mmio;
    logic          w_wr_gpio;
    logic          w_wr_tohost;
    logic [31:0]   w_timer_rdata;
    logic [31:0]   w_mmio_rdata;
    logic [31:0]   w_read_data;

    assign w_ram_hit   = (data_addr_m[31:AW+2] == '0);
    assign w_mmio_hit  = !w_ram_hit && (data_addr_m[31:8] == MMIO_BASE[31:8]);
    assign w_word_idx  = data_addr_m[AW+1:2];
    assign w_off       = data_addr_m[7:2];
    // Timer offsets stay "known" even when the timer is not built, so they never raise bus_err.
    assign w_off_known = (w_off <= OFF_TIMER_ACK);

    assign w_wr_ram    = mem_write && w_ram_hit;
    assign w_wr_mmio   = mem_write && w_mmio_hit;
    assign w_wr_gpio   = w_wr_mmio && (w_off == OFF_GPIO);
    assign w_wr_tohost = w_wr_mmio && (w_off == OFF_TOHOST);

    // NOTE: RAM has no reset; it lives in its own clock-only process so it can map to memory.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_mem[w_word_idx] <= write_data_m;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cycle        <= '0;
            r_gpio         <= '0;
            r_done         <= 1'b0;
            r_exit_code    <= '0;
            r_bus_err      <= 1'b0;
            r_misalign_err <= 1'b0;
        end else begin
            if (!r_done) begin
                r_cycle <= r_cycle + 64'd1;
            end
            if (w_wr_gpio) begin
                r_gpio <= write_data_m;
            end
            if (w_wr_tohost && !r_done) begin
                r_done      <= 1'b1;
                r_exit_code <= write_data_m;
            end
            if (mem_write && !(w_ram_hit || (w_mmio_hit && w_off_known))) begin
                r_bus_err <= 1'b1;
            end
            if (mem_write && (data_addr_m[1:0] != 2'b00)) begin
                r_misalign_err <= 1'b1;
            end
        end
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] r_timer;
    logic        r_timer_irq;
    logic        w_wr_timer;
    logic        w_wr_timer_ack;
    logic        w_timer_expire;

    assign w_wr_timer     = w_wr_mmio && (w_off == OFF_TIMER);
    assign w_wr_timer_ack = w_wr_mmio && (w_off == OFF_TIMER_ACK);
    assign w_timer_expire = (r_timer == 32'd1);

    // Expiry beats both a reload and an ack arriving on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer     <= '0;
            r_timer_irq <= 1'b0;
        end else begin
            if (w_wr_timer) begin
                r_timer <= write_data_m;
            end else if (r_timer != 32'd0) begin
                r_timer <= r_timer - 32'd1;
            end
            if (w_timer_expire) begin
                r_timer_irq <= 1'b1;
            end else if (w_wr_timer_ack) begin
                r_timer_irq <= 1'b0;
            end
        end
    end

    assign w_timer_rdata = r_timer;
    assign timer_irq     = r_timer_irq;
`else
    assign w_timer_rdata = '0;
    assign timer_irq     = 1'b0;
`endif

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_mmio_rdata = '0;
        case (w_off)
            OFF_CYCLE_LO: w_mmio_rdata = r_cycle[31:0];
            OFF_CYCLE_HI: w_mmio_rdata = r_cycle[63:32];
            OFF_GPIO:     w_mmio_rdata = r_gpio;
            OFF_TOHOST:   w_mmio_rdata = r_exit_code;
            OFF_TIMER:    w_mmio_rdata = w_timer_rdata;
            default:      w_mmio_rdata = '0;
        endcase
    end

    always_comb begin
        w_read_data = BAD_READ;
        if (w_ram_hit) begin
            w_read_data = r_mem[w_word_idx];
        end else if (w_mmio_hit) begin
            w_read_data = w_mmio_rdata;
        end
    end

    assign read_data_m  = w_read_data;
    assign gpio_out     = r_gpio;
    assign done         = r_done;
    assign exit_code    = r_exit_code;
    assign bus_err      = r_bus_err;
    assign misalign_err = r_misalign_err;
endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench for data_mem_responder: directed literal checks plus a
// randomized run compared every cycle against a behavioural model.
module tb_data_mem_responder;
    localparam int          DEPTH     = 1024;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
    localparam logic [31:0] BAD_READ  = 32'hDEAD_BEEF;
`ifdef DMEM_TIMER_EN
    localparam bit TIMER_EN = 1'b1;
`else
    localparam bit TIMER_EN = 1'b0;
`endif
    localparam logic [31:0] A_CYC_LO = MMIO_BASE + 32'h00;
    localparam logic [31:0] A_CYC_HI = MMIO_BASE + 32'h04;
    localparam logic [31:0] A_GPIO   = MMIO_BASE + 32'h08;
    localparam logic [31:0] A_TOHOST = MMIO_BASE + 32'h0C;
    localparam logic [31:0] A_TIMER  = MMIO_BASE + 32'h10;
    localparam logic [31:0] A_ACK    = MMIO_BASE + 32'h14;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] data_addr_m = '0;
    logic [31:0] write_data_m = '0;
    logic [31:0] read_data_m, gpio_out, exit_code;
    logic        done, timer_irq, bus_err, misalign_err;

    int checks = 0;
    int failures = 0;

    data_mem_responder #(.DEPTH(DEPTH), .MMIO_BASE(MMIO_BASE), .BAD_READ(BAD_READ)) dut (
        .clk(clk), .rst(rst), .mem_write(mem_write), .data_addr_m(data_addr_m),
        .write_data_m(write_data_m), .read_data_m(read_data_m), .gpio_out(gpio_out),
        .done(done), .exit_code(exit_code), .timer_irq(timer_irq),
        .bus_err(bus_err), .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: architectural state after each edge.
    logic [31:0] m_mem [DEPTH];
    bit          m_valid [DEPTH];
    bit   [63:0] m_cyc = '0;
    logic [31:0] m_gpio = '0, m_exit = '0, m_tcount = '0;
    bit          m_done = 0, m_irq = 0, m_bus = 0, m_mis = 0;

    function automatic bit is_ram(input logic [31:0] a);
        return a < 32'(4 * DEPTH);
    endfunction

    function automatic bit is_mmio(input logic [31:0] a);
        return !is_ram(a) && (a[31:8] == MMIO_BASE[31:8]);
    endfunction

    function automatic bit read_known(input logic [31:0] a);
        return !is_ram(a) || m_valid[int'(a >> 2)];
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        if (is_ram(a)) return m_mem[int'(a >> 2)];
        if (!is_mmio(a)) return BAD_READ;
        case (a[7:0] & 8'hFC)
            8'h00:   return m_cyc[31:0];
            8'h04:   return m_cyc[63:32];
            8'h08:   return m_gpio;
            8'h0C:   return m_exit;
            8'h10:   return TIMER_EN ? m_tcount : 32'h0;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step(input logic we, input logic [31:0] a, input logic [31:0] d);
        bit was_done, expire;
        was_done = m_done;
        expire   = TIMER_EN && (m_tcount == 32'd1);
        if (m_tcount != 0) m_tcount = m_tcount - 1;
        if (we) begin
            if (a[1:0] != 2'b00) m_mis = 1;
            if (is_ram(a)) begin
                m_mem[int'(a >> 2)]   = d;
                m_valid[int'(a >> 2)] = 1;
            end else if (is_mmio(a)) begin
                case (a[7:0] & 8'hFC)
                    8'h00, 8'h04: ;
                    8'h08: m_gpio = d;
                    8'h0C: if (!m_done) begin m_done = 1; m_exit = d; end
                    8'h10: if (TIMER_EN) m_tcount = d;
                    8'h14: if (TIMER_EN) m_irq = 0;
                    default: m_bus = 1;
                endcase
            end else begin
                m_bus = 1;
            end
        end
        if (expire) m_irq = 1;
        if (!was_done) m_cyc = m_cyc + 1;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_cyc = '0; m_gpio = '0; m_exit = '0; m_tcount = '0;
            m_done = 0; m_irq = 0; m_bus = 0; m_mis = 0;
        end else begin
            model_step(mem_write, data_addr_m, write_data_m);
        end
    end

    // Compare process, on the falling edge.
    always @(negedge clk) begin
        check("gpio_out", gpio_out, m_gpio);
        check("done", {31'b0, done}, {31'b0, m_done});
        check("exit_code", exit_code, m_exit);
        check("timer_irq", {31'b0, timer_irq}, {31'b0, m_irq});
        check("bus_err", {31'b0, bus_err}, {31'b0, m_bus});
        check("misalign_err", {31'b0, misalign_err}, {31'b0, m_mis});
        if (read_known(data_addr_m)) check("read_data_m", read_data_m, model_read(data_addr_m));
    end

    // Called at posedge+1; the write lands on the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1; data_addr_m = a; write_data_m = d;
        @(posedge clk); #1;
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        mem_write = 1'b0; data_addr_m = a;
        #1 v = read_data_m;
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, a, d;
        int r, sel;
        logic [31:0] offs [5] = '{32'h00, 32'h04, 32'h08, 32'h10, 32'h14};

        tick(3);
        check("rst gpio", gpio_out, 32'h0);
        check("rst flags", {26'b0, done, timer_irq, bus_err, misalign_err, 2'b0}, 32'h0);
        rst = 1'b0;

        tick(100);
        rd(A_CYC_LO, v); check("cycle_lo@100", v, 32'd100);
        rd(A_CYC_HI, v); check("cycle_hi@100", v, 32'd0);

        wr(32'h0, 32'hA5A5_0000);
        wr(32'h40, 32'h1234_5678);
        rd(32'h40, v); check("ram 0x40", v, 32'h1234_5678);
        rd(32'h43, v); check("ram 0x43", v, 32'h1234_5678);
        check("no misalign on read", {31'b0, misalign_err}, 32'h0);

        wr(32'h0000_8000, 32'h1);
        check("bus_err set", {31'b0, bus_err}, 32'h1);
        rd(32'h0, v); check("ram word0 untouched", v, 32'hA5A5_0000);
        rd(32'h0000_8000, v); check("unmapped read", v, 32'hDEAD_BEEF);
        wr(32'h42, 32'hCAFE_F00D);
        check("misalign set", {31'b0, misalign_err}, 32'h1);
        rd(32'h40, v); check("misaligned write lands", v, 32'hCAFE_F00D);

        wr(A_GPIO, 32'h0000_00FF);
        check("gpio 0xFF", gpio_out, 32'h0000_00FF);
        rd(A_MMIO_UNIMPL(), v); check("unimpl mmio read", v, 32'h0);

        wr(A_TIMER, 32'd3);
        check("irq t+0", {31'b0, timer_irq}, 32'h0);
        tick(1); check("irq t+1", {31'b0, timer_irq}, 32'h0);
        tick(1); check("irq t+2", {31'b0, timer_irq}, 32'h0);
        tick(1); check("irq t+3", {31'b0, timer_irq}, {31'b0, TIMER_EN});
        wr(A_ACK, 32'h0);
        check("irq acked", {31'b0, timer_irq}, 32'h0);
        wr(A_TIMER, 32'd1);
        wr(A_ACK, 32'h0);
        check("ack vs expiry", {31'b0, timer_irq}, {31'b0, TIMER_EN});
        rd(A_ACK, v); check("ack reads 0", v, 32'h0);
        wr(A_ACK, 32'h0);
        wr(A_TIMER, 32'd1000);
        rd(A_TIMER, v); check("timer count", v, TIMER_EN ? 32'd1000 : 32'd0);

        for (int i = 0; i < 50; i++) begin
            mem_write = 1'b0; write_data_m = $urandom;
            data_addr_m = MMIO_BASE + 32'(i % 64) * 4 + 32'(i % 4);
            tick(1);
        end
        check("sweep gpio", gpio_out, 32'h0000_00FF);
        check("sweep done", {31'b0, done}, 32'h0);
        check("sweep irq", {31'b0, timer_irq}, 32'h0);

        for (int i = 0; i < 2000; i++) begin
            r = $urandom_range(0, 99);
            d = $urandom;
            a = 32'h0;
            if (r < 35) begin
                a = 32'($urandom_range(32, 95)) * 4;
                if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
            end else if (r < 50) begin
                sel = $urandom_range(0, 4);
                a = MMIO_BASE + offs[sel];
                if ($urandom_range(0, 9) == 0) a = a + 32'($urandom_range(1, 3));
                if (sel == 3) d = 32'($urandom_range(0, 6));
            end else if (r < 55) begin
                a = 32'h0001_0000 + 32'($urandom_range(0, 1000)) * 4;
            end else begin
                case ($urandom_range(0, 2))
                    0: a = 32'($urandom_range(128, 383));
                    1: a = MMIO_BASE + 32'($urandom_range(0, 255));
                    default: a = $urandom;
                endcase
            end
            mem_write = (r < 55); data_addr_m = a; write_data_m = d;
            tick(1);
        end
        mem_write = 1'b0;

        wr(A_GPIO, 32'h0000_00FF);
        wr(A_TIMER, 32'd1000);
        tick(2);
        check("pre-reset gpio", gpio_out, 32'h0000_00FF);
        #2 rst = 1'b1;
        #1;
        check("async rst gpio", gpio_out, 32'h0);
        check("async rst exit", exit_code, 32'h0);
        check("async rst flags", {28'b0, done, timer_irq, bus_err, misalign_err}, 32'h0);
        tick(2);
        rst = 1'b0;
        rd(32'h40, v); check("ram survives reset", v, 32'hCAFE_F00D);
        rd(A_TIMER, v); check("timer cleared", v, 32'h0);

        tick(20);
        wr(A_TOHOST, 32'h1);
        check("done set", {31'b0, done}, 32'h1);
        check("exit_code 1", exit_code, 32'h1);
        rd(A_CYC_LO, v); check("cycle frozen a", v, 32'd21);
        tick(10);
        rd(A_CYC_LO, v); check("cycle frozen b", v, 32'd21);
        wr(A_TOHOST, 32'h5);
        check("exit_code sticky", exit_code, 32'h1);
        rd(A_TOHOST, v); check("tohost read", v, 32'h1);
        tick(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic logic [31:0] A_MMIO_UNIMPL();
        return MMIO_BASE + 32'h40;
    endfunction
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory port.
- Takes the core's M-stage signals and returns read_data_m in the same cycle: mem_write, data_addr_m and write_data_m come in, read_data_m goes out.
- Decodes a word-addressed data RAM plus a small MMIO register page:
  - free-running cycle counter
  - GPIO output register
  - test-exit (tohost) register
  - countdown timer
- Flags bad accesses with sticky error outputs.

Parameters:
- DEPTH, 1024: RAM words. Must be a power of 2. RAM occupies byte addresses 0 .. 4*DEPTH-1.
- MMIO_BASE, 32'hFFFF_0000: byte base of the MMIO page. Page is 256 bytes, decode on addr[31:8].
- BAD_READ, 32'hDEAD_BEEF: value returned for unmapped reads.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous active-high reset
- mem_write  in  1  write strobe from core M stage
- data_addr_m  in  32  byte address from core M stage
- write_data_m  in  32  store data from core M stage
- read_data_m  out  32  combinational read data, valid same cycle as address
- gpio_out  out  32  GPIO register contents
- done  out  1  sticky, set by a write to TOHOST
- exit_code  out  32  data latched by the first TOHOST write
- timer_irq  out  1  sticky, timer expired
- bus_err  out  1  sticky, write to an unmapped address
- misalign_err  out  1  sticky, write with addr[1:0] != 0

Behaviour:
- Read path:
  - Purely combinational; no side effects. The address bus carries ALU results for non-load instructions, so a read must never change state.
  - addr[1:0] ignored on reads.
  - RAM hit returns mem[addr[log2(DEPTH)+1:2]].
  - MMIO hit returns the register value; unimplemented MMIO offsets return 0.
  - Anything else returns BAD_READ.
- Write path:
  - Performed on the rising edge when mem_write=1. Word writes only; addr[1:0] ignored for the target.
  - Misaligned write: the write still proceeds and misalign_err is set.
  - Unmapped write: no state change and bus_err is set.
- MMIO map (offset from MMIO_BASE):
  - 0x00 CYCLE_LO (RO): low word of the 64-bit cycle counter.
  - 0x04 CYCLE_HI (RO): high word of the cycle counter.
    - Counter increments every cycle while done=0 and freezes once done=1.
    - Wraps 2^64-1 -> 0.
    - Writes to CYCLE_LO/CYCLE_HI are ignored with no error.
  - 0x08 GPIO (RW): gpio_out = register contents.
  - 0x0C TOHOST (RW):
    - First write sets done=1 and latches exit_code.
    - Later writes are ignored while done=1.
    - Reads return exit_code.
  - 0x10 TIMER (RW):
    - Write loads a 32-bit count.
    - While the count is nonzero it decrements by 1 per cycle.
    - The cycle the count goes 1->0 sets timer_irq.
    - Writing 0 stops the timer without setting irq.
  - 0x14 TIMER_ACK (WO): any write clears timer_irq. Reads return 0.
- Simultaneous events:
  - TIMER write in the same cycle as a 1->0 expiry: the loaded value wins and timer_irq is still set.
  - TIMER_ACK in the same cycle as an expiry: set wins, so timer_irq stays 1.
- Reset (async, any time, including mid-countdown):
  - gpio_out=0, done=0, exit_code=0, timer_irq=0, bus_err=0, misalign_err=0.
  - Cycle counter=0, timer count=0.
  - RAM contents are not reset.
- Latency:
  - Read data arrives in zero cycles.
  - A write is visible to reads from the cycle after the edge it was written on.

Optional Feature:
- Macro DMEM_TIMER_EN.
- Defined: TIMER, TIMER_ACK and timer_irq behave as above.
- Undefined:
  - No timer logic is built.
  - Offsets 0x10 and 0x14 read 0; writes to them are ignored with no error.
  - timer_irq is tied to 0.

Test Plan:
- RAM: write 32'h1234_5678 to 0x40, then read 0x40 -> 32'h1234_5678 from the next cycle. Read 0x43 -> same value, misalign_err stays 0.
- Bad accesses:
  - Write 0x1 to 0x0000_8000 (DEPTH=1024) -> bus_err=1, RAM unchanged.
  - Read 0x0000_8000 -> 32'hDEAD_BEEF.
  - Write to 0x42 -> misalign_err=1, word 0x40 updated.
- Cycle counter: release reset, wait 100 cycles -> CYCLE_LO reads 100 (+/-0 per the edge definition), CYCLE_HI reads 0. Write TOHOST=0x1 -> done=1, exit_code=1, and CYCLE_LO holds constant from then on.
- Timer (DMEM_TIMER_EN):
  - Write TIMER=3 -> timer_irq rises exactly 3 cycles after the write edge.
  - Write TIMER_ACK -> timer_irq=0.
  - Write TIMER=1 with ACK in the expiry cycle -> timer_irq=1.
- Reset mid-run: assert rst asynchronously mid-countdown with gpio_out=0xFF -> all outputs 0 immediately, without waiting for a clock edge. RAM word 0x40 still reads its old value after release.
- Read side-effect check: sweep data_addr_m over all MMIO offsets with mem_write=0 for 50 cycles -> timer_irq unchanged, done unchanged, GPIO unchanged.
